// File: rtl/control_pkg.sv
// control_pkg: state encodings, instruction field constants, instruction classes and
// the per-state registered output pattern shared by the control unit.
package control_pkg;

   localparam int TYPE_W   = 3;
   localparam int OPCODE_W = 5;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   localparam logic [TYPE_W-1:0] TYPE_NOP    = 3'b000;
   localparam logic [TYPE_W-1:0] TYPE_ALU    = 3'b001;
   localparam logic [TYPE_W-1:0] TYPE_CONST  = 3'b010;
   localparam logic [TYPE_W-1:0] TYPE_MEM    = 3'b100;
   localparam logic [TYPE_W-1:0] TYPE_BRANCH = 3'b110;

   localparam logic [OPCODE_W-1:0] OP_ADD    = 5'b00000;
   localparam logic [OPCODE_W-1:0] OP_ADDINC = 5'b00001;
   localparam logic [OPCODE_W-1:0] OP_SUB    = 5'b00011;
   localparam logic [OPCODE_W-1:0] OP_AND    = 5'b00100;
   localparam logic [OPCODE_W-1:0] OP_OR     = 5'b00101;
   localparam logic [OPCODE_W-1:0] OP_XOR    = 5'b00110;
   localparam logic [OPCODE_W-1:0] OP_SHL    = 5'b01000;
   localparam logic [OPCODE_W-1:0] OP_SHR    = 5'b01001;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_LOADLIT,
      CLS_NOP,
      CLS_BRANCH,
      CLS_ILLEGAL
   } class_t;

   // Registered strobes; memory strobes are active-low.
   typedef struct packed {
      logic                mem_read_n;
      logic                mem_write_n;
      logic                mem_to_reg;
      logic [OPCODE_W-1:0] alu_op;
      logic                alu_src;
      logic                reg_write;
      logic                fault;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{
      mem_read_n:  1'b1,
      mem_write_n: 1'b1,
      mem_to_reg:  1'b0,
      alu_op:      '0,
      alu_src:     1'b0,
      reg_write:   1'b0,
      fault:       1'b0
   };

   // The whole upper half of the opcode space is the extended ALU group.
   function automatic logic alu_opcode_legal(input logic [OPCODE_W-1:0] op);
      return op[OPCODE_W-1] ||
             (op inside {OP_ADD, OP_ADDINC, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR});
   endfunction

   function automatic ctrl_t state_outputs(input state_t              st,
                                           input class_t              cls,
                                           input logic [OPCODE_W-1:0] op);
      ctrl_t o;
      o = CTRL_IDLE;
      case (st)
         ST_FETCH: o.mem_read_n = 1'b0;
         ST_EXEC: begin
            case (cls)
               CLS_ALU:                          o.alu_op  = op;
               CLS_LOAD, CLS_STORE, CLS_LOADLIT: o.alu_src = 1'b1;
               default: ;
            endcase
         end
         ST_MEM: begin
            o.alu_src     = 1'b1;
            o.mem_read_n  = (cls != CLS_LOAD);
            o.mem_write_n = (cls != CLS_STORE);
         end
         ST_WB: begin
            o.reg_write  = 1'b1;
            o.mem_to_reg = (cls == CLS_LOAD);
         end
         ST_TRAP: o.fault = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: maps the latched type/opcode fields to an instruction class.
// CONTROL_BRANCH_EN enables decoding of the branch type; without it that type is illegal.
module control_decode
   import control_pkg::*;
(
   input  logic [TYPE_W-1:0]   ir_type,
   input  logic [OPCODE_W-1:0] opcode,
   output class_t              cls
);

   always_comb begin
      // NOTE: default assignment first, so no path through the case leaves cls unassigned (no latch).
      cls = CLS_ILLEGAL;
      case (ir_type)
         TYPE_NOP:   cls = CLS_NOP;
         TYPE_ALU:   if (alu_opcode_legal(opcode)) cls = CLS_ALU;
         TYPE_MEM:   cls = opcode[0] ? CLS_STORE : CLS_LOAD;
         TYPE_CONST: if (opcode[1:0] == 2'b10) cls = CLS_LOADLIT;
`ifdef CONTROL_BRANCH_EN
         TYPE_BRANCH: cls = CLS_BRANCH;
`endif
         default:    cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with memory-ready handshake,
// illegal-opcode trap and memory-wait timeout. Define CONTROL_BRANCH_EN to enable branches.
module control_fsm
   import control_pkg::*;
#(
   parameter int INSTR_W     = 32,
   parameter int ALUOP_W     = 5,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               memReady,
   input  logic               zeroFlag,
   output logic               branch,
   output logic               memRead,
   output logic               memWrite,
   output logic               memToReg,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               ALUSrc,
   output logic               regWrite,
   output logic               enablePC,
   output logic               irWrite,
   output logic               fault,
   output logic [2:0]         state
);

   localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [TYPE_W-1:0]   ir_type_q;
   logic [OPCODE_W-1:0] ir_op_q;
   ctrl_t               ctrl_q;
   class_t              cls;
   logic                fetch_done;
   logic                br_taken;

   logic [INSTR_W-9:0]  unused_instr;
   assign unused_instr = instruction[INSTR_W-9:0];

   control_decode u_decode (
      .ir_type (ir_type_q),
      .opcode  (ir_op_q),
      .cls     (cls)
   );

   assign fetch_done = (state_q == ST_FETCH) && memReady;

`ifdef CONTROL_BRANCH_EN
   // zeroFlag is the ALU result of this same EXEC cycle, so the decision stays combinational.
   assign br_taken = (state_q == ST_EXEC) && (cls == CLS_BRANCH) && (!ir_op_q[0] || zeroFlag);
`else
   logic unused_zero;
   assign unused_zero = zeroFlag;
   assign br_taken    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_FETCH: begin
            if (memReady)              state_d = ST_DECODE;
            else if (cnt_q == CNT_LAST) state_d = ST_TRAP;
            else                        cnt_d   = cnt_q + 1'b1;
         end
         ST_DECODE: begin
            case (cls)
               CLS_NOP:     state_d = ST_FETCH;
               CLS_ILLEGAL: state_d = ST_TRAP;
               default:     state_d = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            case (cls)
               CLS_ALU, CLS_LOADLIT: state_d = ST_WB;
               CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
               default:              state_d = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            // A ready arriving in the expiry cycle still completes the access.
            if (memReady)               state_d = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
            else if (cnt_q == CNT_LAST) state_d = ST_TRAP;
            else                        cnt_d   = cnt_q + 1'b1;
         end
         ST_WB:   state_d = ST_FETCH;
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_TRAP;
      endcase

      if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
         cnt_d = '0;
      end
   end

   // Registered outputs are loaded with the pattern of the state being entered.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) begin
         state_q   <= ST_FETCH;
         cnt_q     <= '0;
         ir_type_q <= '0;
         ir_op_q   <= '0;
         ctrl_q    <= CTRL_IDLE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (fetch_done) begin
            ir_type_q <= instruction[INSTR_W-1 -: TYPE_W];
            ir_op_q   <= instruction[INSTR_W-4 -: OPCODE_W];
         end
         ctrl_q <= state_outputs(state_d, cls, ir_op_q);
      end
   end

   assign branch   = br_taken;
   assign enablePC = fetch_done | br_taken;
   assign irWrite  = fetch_done;
   assign memRead  = ctrl_q.mem_read_n;
   assign memWrite = ctrl_q.mem_write_n;
   assign memToReg = ctrl_q.mem_to_reg;
   assign ALUOp    = ALUOP_W'(ctrl_q.alu_op);
   assign ALUSrc   = ctrl_q.alu_src;
   assign regWrite = ctrl_q.reg_write;
   assign fault    = ctrl_q.fault;
   assign state    = state_q;

endmodule
